sum_sq_accum: RTL and testbench
===============================

SUM_SQ_ACCUM -- requirements
Module: sum_sq_accum

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning the width of the sample-count field (max frame = 2^LEN_W-1 samples).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, meaning a request to begin a frame; sampled only in IDLE.
REQ-005 SHALL have port len, input, LEN_W, meaning the number of samples in the frame; captured with start.
REQ-006 SHALL have port in_valid, input, 1, meaning in_data holds a valid sample.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-008 SHALL have port in_data, input, 16, meaning a two's-complement signed sample.
REQ-009 SHALL have port out_valid, output, 1, meaning out_sum and out_sat are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the downstream 32-bit square-root stage consumes the result.
REQ-011 SHALL have port out_sum, output, 32, meaning the unsigned sum of squares for the frame.
REQ-012 SHALL have port out_sat, output, 1, meaning out_sum was clamped to 0xFFFF_FFFF.
REQ-013 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-014 SHALL implement a three-state machine: IDLE, ACCUM, HOLD.
REQ-015 SHALL, in IDLE with start=1 and len!=0, clear the accumulator, load the remaining count with len, clear the saturation flag, and enter ACCUM next cycle.
REQ-016 SHALL, in IDLE with start=1 and len==0, enter HOLD next cycle with out_sum=0 and out_sat=0.
REQ-017 SHALL drive in_ready=1 only in ACCUM; a sample is accepted when in_valid and in_ready are both 1.
REQ-018 SHALL compute each square as in_data*in_data, signed, giving an unsigned 31-bit result; -32768 gives 0x4000_0000.
REQ-019 SHALL add the square to the accumulator with a 33-bit sum; if bit 32 is set or saturation is already flagged, it SHALL load 0xFFFF_FFFF and set the flag.
REQ-020 SHALL decrement the remaining count on each accepted sample; when accepting the sample with count==1, it SHALL enter HOLD next cycle.
REQ-021 SHALL assert out_valid exactly in HOLD, one cycle after the last sample is accepted.
REQ-022 SHALL hold out_sum and out_sat stable while out_valid=1 and out_ready=0.
REQ-023 SHALL return to IDLE on the cycle after out_valid and out_ready are both 1; out_ready has no effect outside HOLD.
REQ-024 SHALL ignore start outside IDLE; len SHALL be ignored except when captured.
REQ-025 SHALL leave ACCUM only by sample count; in_valid gaps stall the frame indefinitely without changing state.
REQ-026 SHALL not accept a new start in the same cycle as the HOLD handshake; the earliest next start is taken in IDLE.
REQ-027 SHALL keep out_sum at the last frame result in IDLE; it is only meaningful while out_valid=1.

Reset
REQ-028 SHALL, on rst_n=0 and independent of clk, force IDLE, accumulator=0, count=0, out_sum=0, out_sat=0, out_valid=0, in_ready=0, busy=0.
REQ-029 SHALL, on reset during ACCUM or HOLD, abort the frame and produce no out_valid for it.
REQ-030 SHALL leave IDLE after reset release only on a sampled start.

Verification
REQ-031 Bench SHALL drive len=3, samples 3,-4,12 back-to-back -> out_valid one cycle after the third accept, out_sum=169, out_sat=0.
REQ-032 Bench SHALL drive len=4, all samples -32768 -> out_sum=0xFFFF_FFFF, out_sat=1 (sum 2^32 overflows on the 4th sample).
REQ-033 Bench SHALL drive len=0 start -> HOLD next cycle, out_sum=0, out_sat=0, in_ready never asserted.
REQ-034 Bench SHALL drive len=2 with in_valid gaps and out_ready=0 for 5 cycles -> correct sum, out_valid and out_sum stable until out_ready=1, then IDLE.
REQ-035 Bench SHALL assert start in ACCUM with a different len, then reset mid-frame -> the start has no effect; on reset all outputs are 0 immediately and no result is produced.
REQ-036 Bench SHALL run random frames against a reference model -> out_sum equals min(sum of squares, 0xFFFF_FFFF) for every frame.

Source files
------------

// File: rtl/sum_sq_accum.sv
// Frame-based sum-of-squares accumulator with saturation and a ready/valid
// result handshake toward a downstream 32-bit square-root stage.
module sum_sq_accum #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic signed [31:0] sq;
    logic [32:0]        sum33;
    logic               accept;

    // A signed square is never negative, so the top product bit is always zero.
    assign sq     = $signed(in_data) * $signed(in_data);
    assign sum33  = {1'b0, acc_q} + {1'b0, sq};
    assign accept = in_valid && (state_q == ACCUM);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                    cnt_d = len;
                    if (len == '0) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (sum33[32] || sat_q) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum33[31:0];
                    end
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_sum_sq_accum.sv
// Directed and random-frame bench for sum_sq_accum; every result is checked
// against hand-computed constants or an independent 64-bit sum model.
module tb_sum_sq_accum;

    localparam int unsigned LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic             out_sat;
    logic             busy;

    int nvec = 0;
    int nerr = 0;

    sum_sq_accum #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sample was accepted.
    task automatic send(input logic [15:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 64'd1, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max_cyc);
        int t;
        t = 0;
        while (!out_valid && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        if (t >= max_cyc) chk("out_timeout", 64'd1, 64'd0);
    endtask

    task automatic begin_frame(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        len   = '0;
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint     model;
        int         flen;
        logic [15:0] s;

        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_sum", out_sum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start", busy, 1'b0);

        // len=3: 9 + 16 + 144 = 169
        begin_frame(8'd3);
        chk("f1_in_ready", in_ready, 1'b1);
        send(16'd3);
        send(-16'sd4);
        send(16'd12);
        chk("f1_out_valid", out_valid, 1'b1);
        chk("f1_sum", out_sum, 32'd169);
        chk("f1_sat", out_sat, 1'b0);
        handshake();
        chk("f1_idle", busy, 1'b0);
        chk("f1_sum_kept", out_sum, 32'd169);

        // 4 x 2^30 overflows 32 bits on the 4th sample
        begin_frame(8'd4);
        repeat (4) send(16'h8000);
        chk("f2_out_valid", out_valid, 1'b1);
        chk("f2_sum", out_sum, 32'hFFFF_FFFF);
        chk("f2_sat", out_sat, 1'b1);
        handshake();

        // len=0 goes straight to HOLD
        begin_frame(8'd0);
        chk("f3_out_valid", out_valid, 1'b1);
        chk("f3_in_ready", in_ready, 1'b0);
        chk("f3_sum", out_sum, 32'd0);
        chk("f3_sat", out_sat, 1'b0);
        // start during the HOLD handshake is taken only once back in IDLE
        start = 1'b1; len = 8'd1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("f3_hs_idle", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("f3b_accum", in_ready, 1'b1);
        send(16'd5);
        chk("f3b_sum", out_sum, 32'd25);
        handshake();

        // len=2 with gaps: 100^2 + 7^2 = 10049, result held under backpressure
        begin_frame(8'd2);
        repeat (3) @(negedge clk);
        chk("f4_gap_ready", in_ready, 1'b1);
        send(16'd100);
        repeat (2) @(negedge clk);
        chk("f4_gap_valid", out_valid, 1'b0);
        send(-16'sd7);
        for (int i = 0; i < 5; i++) begin
            chk("f4_hold_valid", out_valid, 1'b1);
            chk("f4_hold_sum", out_sum, 32'd10049);
            @(negedge clk);
        end
        handshake();
        chk("f4_idle", busy, 1'b0);

        // start in ACCUM ignored, then reset mid-frame
        begin_frame(8'd5);
        send(16'd1);
        start = 1'b1; len = 8'd1;
        send(16'd2);
        start = 1'b0; len = '0;
        chk("f5_still_accum", in_ready, 1'b1);
        chk("f5_no_valid", out_valid, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("f5_rst_busy", busy, 1'b0);
        chk("f5_rst_ready", in_ready, 1'b0);
        chk("f5_rst_sum", out_sum, 32'd0);
        chk("f5_rst_sat", out_sat, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("f5_post_rst_valid", out_valid, 1'b0);
        end

        // random frames against a 64-bit model clamped at the end
        for (int f = 0; f < 12; f++) begin
            flen  = (f % 3 == 2) ? int'($urandom_range(5, 8)) : int'($urandom_range(1, 6));
            model = 0;
            begin_frame(LEN_W'(flen));
            for (int k = 0; k < flen; k++) begin
                s = (f % 3 == 2) ? 16'($urandom_range(30000, 65535)) : 16'($urandom);
                model += longint'($signed(s)) * longint'($signed(s));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send(s);
            end
            wait_out(5);
            chk("rnd_sum", out_sum, (model > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : model);
            chk("rnd_sat", out_sat, (model > 64'hFFFF_FFFF) ? 1'b1 : 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            handshake();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
